// File: rtl/count_sched.sv
`timescale 1ns/1ps
// count_sched: round-robin arbiter lending one shared CW-bit counter to NREQ requesters.
// Latency: gnt 1 cycle after req is seen idle, done len+2 cycles after gnt; losers simply hold req.
module count_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] req_len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_rstn,
    output logic              cnt_en,
    input  logic [CW-1:0]     cnt_val
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   len_q, len_d;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   ptr_inc;
    logic            req_granted;
    logic [CW-1:0]   win_len;

    // First asserted request found walking ptr, ptr+1, ... wrapping at NREQ.
    always_comb begin
        logic [PW1-1:0] sum;
        logic [PW-1:0]  idx;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + PW1'(k);
            if (sum >= PW1'(NREQ)) begin
                sum = sum - PW1'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    assign ptr_inc     = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    assign req_granted = |(req & gnt_q);
    assign win_len     = req_len[int'(win_idx) * CW +: CW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    len_d          = win_len;
                    state_d        = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_COUNT;
            end
            S_COUNT: begin
                // Enable drops at equality, so len = 2^CW-1 never wraps the counter.
                cnt_en = (cnt_val < len_q) && req_granted;
                if (!req_granted) begin
                    ptr_d   = ptr_inc;
                    state_d = S_IDLE;
                end else if (cnt_val >= len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = ptr_inc;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
        end
    end

    assign gnt      = (state_q != S_IDLE) ? gnt_q : '0;
    assign done     = (state_q == S_DONE) ? gnt_q : '0;
    assign busy     = (state_q != S_IDLE);
    assign cnt_rstn = !(rst || (state_q == S_CLEAR));

endmodule

// File: tb/tb_count_sched.sv
`timescale 1ns/1ps
// Randomised and directed bench for count_sched against a job-level reference model.
module tb_count_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic           cnt_rstn;
    logic           cnt_en;
    logic [W-1:0]   cnt;

    count_sched #(.NREQ(N), .CW(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_len  (req_len),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .cnt_rstn (cnt_rstn),
        .cnt_en   (cnt_en),
        .cnt_val  (cnt)
    );

    always #5 clk = ~clk;

    // The shared counter: synchronous active-low clear, count enable.
    always @(posedge clk) begin
        if (!cnt_rstn)   cnt <= '0;
        else if (cnt_en) cnt <= cnt + 4'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Job-level model: a job is owner, length and age in cycles since grant.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_len = 0;
    int m_age = 0;
    int m_ptr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!m_busy && req[i]) begin
                    m_busy  = 1'b1;
                    m_owner = i;
                    m_len   = int'(req_len[i*W +: W]);
                    m_age   = 0;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age <= m_len + 1) begin
            if (!req[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end else begin
                m_age++;
            end
        end else begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int eg, ed, een, erst, ecnt;
            eg   = m_busy ? (1 << m_owner) : 0;
            ed   = (m_busy && m_age == m_len + 2) ? eg : 0;
            een  = (m_busy && m_age >= 1 && m_age <= m_len && req[m_owner]) ? 1 : 0;
            erst = (rst || (m_busy && m_age == 0)) ? 0 : 1;
            chk("gnt", int'(gnt), eg);
            chk("done", int'(done), ed);
            chk("busy", int'(busy), m_busy ? 1 : 0);
            chk("cnt_en", int'(cnt_en), een);
            chk("cnt_rstn", int'(cnt_rstn), erst);
            if (m_busy && m_age >= 1) begin
                ecnt = (m_age - 1 < m_len) ? m_age - 1 : m_len;
                chk("cnt_val", int'(cnt), ecnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*W +: W] = W'(v);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic observe(input int lim, output int gc, output int gv, output int dc,
                           output int dv, output int ens, output int cad);
        gc = -1; gv = 0; dc = -1; dv = 0; ens = 0; cad = -1;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (gc < 0 && gnt != '0) begin
                gc = cyc;
                gv = int'(gnt);
            end
            if (cnt_en) ens++;
            if (done != '0) begin
                dc  = cyc;
                dv  = int'(done);
                cad = int'(cnt);
                break;
            end
        end
    endtask

    task automatic collect(input int ngr, input int lim, output int ord[8], output int dcn[N]);
        int got;
        logic [N-1:0] prev;
        got  = 0;
        prev = '0;
        for (int j = 0; j < 8; j++) ord[j] = -1;
        for (int j = 0; j < N; j++) dcn[j] = 0;
        for (int c = 0; c < lim && got < ngr; c++) begin
            @(negedge clk);
            if (done != '0) dcn[oh2i(done)]++;
            if (gnt != '0 && prev == '0) begin
                ord[got] = oh2i(gnt);
                got++;
            end
            prev = gnt;
        end
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    int gc, gv, dc, dv, ens, cad;
    int ord[8];
    int dcn[N];
    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    int exp_fair[4] = '{0, 2, 0, 2};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int flip;
        // Reset state.
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_rstn", int'(cnt_rstn), 0);
        tick();
        rst = 1'b0;

        // Single job, length 3.
        set_len(0, 3);
        req = 4'b0001;
        observe(40, gc, gv, dc, dv, ens, cad);
        chk("t1_gnt", gv, 1);
        chk("t1_done_lat", dc - gc, 5);
        chk("t1_done_vec", dv, 1);
        chk("t1_en_cycles", ens, 3);
        chk("t1_cnt_at_done", cad, 3);
        tick();
        req = '0;
        @(negedge clk);
        chk("t1_idle_after", int'(busy), 0);

        // Zero length.
        tick();
        set_len(2, 0);
        req = 4'b0100;
        observe(40, gc, gv, dc, dv, ens, cad);
        chk("t2_done_vec", dv, 4);
        chk("t2_done_lat", dc - gc, 2);
        chk("t2_en_cycles", ens, 0);
        tick();
        req = '0;

        // Full contention, all lengths 1.
        pulse_reset();
        for (int i = 0; i < N; i++) set_len(i, 1);
        req = 4'b1111;
        collect(5, 100, ord, dcn);
        for (int j = 0; j < 5; j++) chk($sformatf("t3_order%0d", j), ord[j], exp_rr[j]);
        for (int j = 0; j < N; j++) chk($sformatf("t3_dones%0d", j), dcn[j], 1);

        // Fairness between requesters 0 and 2.
        pulse_reset();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 4'b0101;
        collect(4, 100, ord, dcn);
        for (int j = 0; j < 4; j++) chk($sformatf("t4_order%0d", j), ord[j], exp_fair[j]);

        // Abort at cnt_val=2 of length 5.
        pulse_reset();
        set_len(1, 5);
        req = 4'b0010;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy && cnt == 4'd2) break;
        end
        chk("t5_cnt_at_abort", int'(cnt), 2);
        req = '0;
        @(negedge clk);
        chk("t5_en_on_abort", int'(cnt_en), 0);
        chk("t5_done_on_abort", int'(done), 0);
        tick();
        req = 4'b1111;
        @(negedge clk);
        chk("t5_idle", int'(busy), 0);
        @(negedge clk);
        chk("t5_next_gnt", int'(gnt), 4);

        // Reset mid-COUNT with the pointer parked at 3.
        pulse_reset();
        set_len(2, 0);
        req = 4'b0100;
        observe(40, gc, gv, dc, dv, ens, cad);
        tick();
        req = '0;
        tick();
        set_len(2, 9);
        req = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy && cnt == 4'd4) break;
        end
        rst = 1'b1;
        req = 4'b1010;
        @(negedge clk);
        chk("t6_rstn_in_rst", int'(cnt_rstn), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_gnt", int'(gnt), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cnt_en", int'(cnt_en), 0);
        @(negedge clk);
        chk("t6_first_gnt", int'(gnt), 2);

        // Randomised traffic; the per-cycle model does the checking.
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            flip = (c < 1500) ? 7 : 31;
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, flip) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 4))
                        0: set_len(i, 0);
                        1: set_len(i, 15);
                        2: set_len(i, int'($urandom_range(0, 15)));
                        default: set_len(i, int'($urandom_range(1, 3)));
                    endcase
                end
            end
        end
        tick();
        rst = 1'b0;
        req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
